// File: rtl/demux_rr_scheduler.sv
// Round-robin sequencer for a 1-to-4 demux: holds one word and steers it to the
// next enabled channel, with optional multi-word bursts per channel.
module demux_rr_scheduler #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned BURST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [3:0]       en_mask,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic             busy
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned CMP_W = CNT_W + 1;

   typedef enum logic {
      EMPTY  = 1'b0,
      LOADED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [1:0]         sel_q, sel_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         out_valid_q, out_valid_d;
   logic [1:0]         cand;
   logic               xfer;
   logic               accept;

   // First enabled channel at or after base, wrapping modulo 4.
   function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] mask);
      logic [1:0] idx;
      logic [1:0] res;
      res = base;
      for (int k = 3; k >= 0; k--) begin
         idx = base + 2'(k);
         if (mask[idx]) res = idx;
      end
      return res;
   endfunction

   // Pass-through ready: a held word leaving frees the register this same cycle.
   assign in_ready = ((state_q == EMPTY) || out_ready[sel_q]) && (en_mask != 4'd0);
   assign xfer     = (state_q == LOADED) && out_ready[sel_q];
   assign accept   = in_valid && in_ready;

   // Next-state: pointer/burst update on transfer, then candidate from the updated pointer.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      cand        = 2'd0;

      if (xfer) begin
         if ((CMP_W'(cnt_q) + CMP_W'(1)) < CMP_W'(BURST)) begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            ptr_d = sel_q;
         end else begin
            cnt_d = '0;
            ptr_d = 2'(sel_q + 2'd1);
         end
      end

      cand = pick(ptr_d, en_mask);

      if (accept) begin
         state_d     = LOADED;
         data_d      = in_data;
         sel_d       = cand;
         out_valid_d = 4'(4'd1 << cand);
         if (cand != ptr_d) cnt_d = '0;
      end else if (xfer) begin
         state_d     = EMPTY;
         out_valid_d = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         data_q      <= '0;
         sel_q       <= 2'd0;
         ptr_q       <= 2'd0;
         cnt_q       <= '0;
         out_valid_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sel       = sel_q;
   assign out_data  = data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == LOADED);

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Bench for demux_rr_scheduler: BURST=1 and BURST=3 instances driven in parallel,
// checked by vector tables, directed sequences and a cycle-level reference model.
module tb_demux_rr_scheduler;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic [3:0] en_mask;
   logic [3:0] out_ready;

   logic       in_ready_v  [2];
   logic [1:0] sel_v       [2];
   logic [7:0] data_v      [2];
   logic [3:0] ov_v        [2];
   logic       busy_v      [2];

   int n_cmp;
   int n_fail;

   int bursts [2] = '{1, 3};

   // Reference model state, one set per instance
   bit         m_held [2];
   logic [7:0] m_data [2];
   int         m_sel  [2];
   int         m_ptr  [2];
   int         m_cnt  [2];

   bit log_en;
   int xlog0 [$];
   int xlog1 [$];

   demux_rr_scheduler #(.WIDTH(8), .BURST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
      .in_data(in_data), .en_mask(en_mask), .sel(sel_v[0]), .out_data(data_v[0]),
      .out_valid(ov_v[0]), .out_ready(out_ready), .busy(busy_v[0])
   );

   demux_rr_scheduler #(.WIDTH(8), .BURST(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
      .in_data(in_data), .en_mask(en_mask), .sel(sel_v[1]), .out_data(data_v[1]),
      .out_valid(ov_v[1]), .out_ready(out_ready), .busy(busy_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic [3:0] mask;
      logic [3:0] ordy;
      logic       exp_ir;
      logic [3:0] exp_ov;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_held[m] = 1'b0;
         m_data[m] = 8'h00;
         m_sel[m]  = 0;
         m_ptr[m]  = 0;
         m_cnt[m]  = 0;
      end
   endtask

   task automatic check_model();
      logic       exp_ir;
      logic [3:0] exp_ov;
      for (int m = 0; m < 2; m++) begin
         exp_ir = (!m_held[m] || out_ready[m_sel[m]]) && (en_mask != 4'd0);
         exp_ov = m_held[m] ? 4'(1 << m_sel[m]) : 4'd0;
         chk($sformatf("model_in_ready[B%0d]", bursts[m]), 32'(in_ready_v[m]), 32'(exp_ir));
         chk($sformatf("model_out_valid[B%0d]", bursts[m]), 32'(ov_v[m]), 32'(exp_ov));
         chk($sformatf("model_busy[B%0d]", bursts[m]), 32'(busy_v[m]), 32'(m_held[m]));
         if (m_held[m]) begin
            chk($sformatf("model_sel[B%0d]", bursts[m]), 32'(sel_v[m]), 32'(m_sel[m]));
            chk($sformatf("model_data[B%0d]", bursts[m]), 32'(data_v[m]), 32'(m_data[m]));
         end
      end
   endtask

   task automatic model_advance();
      bit xfer;
      bit rdy;
      bit acc;
      int c;
      for (int m = 0; m < 2; m++) begin
         xfer = m_held[m] && out_ready[m_sel[m]];
         rdy  = (!m_held[m] || out_ready[m_sel[m]]) && (en_mask != 4'd0);
         acc  = in_valid && rdy;
         if (xfer) begin
            if (m_cnt[m] + 1 < bursts[m]) begin
               m_cnt[m] = m_cnt[m] + 1;
               m_ptr[m] = m_sel[m];
            end else begin
               m_cnt[m] = 0;
               m_ptr[m] = (m_sel[m] + 1) % 4;
            end
         end
         if (acc) begin
            c = -1;
            for (int k = 0; k < 4; k++)
               if (c < 0 && en_mask[(m_ptr[m] + k) % 4]) c = (m_ptr[m] + k) % 4;
            if (c != m_ptr[m]) m_cnt[m] = 0;
            m_sel[m]  = c;
            m_data[m] = in_data;
            m_held[m] = 1'b1;
         end else if (xfer) begin
            m_held[m] = 1'b0;
         end
      end
   endtask

   task automatic log_transfers();
      logic [3:0] hit;
      for (int m = 0; m < 2; m++) begin
         hit = ov_v[m] & out_ready;
         for (int i = 0; i < 4; i++)
            if (hit[i]) begin
               if (m == 0) xlog0.push_back(i);
               else        xlog1.push_back(i);
            end
      end
   endtask

   // Finish the current cycle: model check, advance across the rising edge.
   task automatic rest();
      check_model();
      if (log_en) log_transfers();
      model_advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tick();
      #1;
      rest();
   endtask

   task automatic drive(input logic iv, input logic [7:0] d, input logic [3:0] mask,
                        input logic [3:0] ordy);
      in_valid  = iv;
      in_data   = d;
      en_mask   = mask;
      out_ready = ordy;
   endtask

   // Mid-cycle async reset: outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rst_out_valid[B%0d]", bursts[m]), 32'(ov_v[m]), 32'd0);
         chk($sformatf("rst_busy[B%0d]", bursts[m]), 32'(busy_v[m]), 32'd0);
         chk($sformatf("rst_sel[B%0d]", bursts[m]), 32'(sel_v[m]), 32'd0);
         chk($sformatf("rst_data[B%0d]", bursts[m]), 32'(data_v[m]), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int exp_seq1 [7];
      int exp_seq3 [7];
      n_cmp  = 0;
      n_fail = 0;
      log_en = 1'b0;
      rst_n  = 1'b0;
      drive(1'b0, 8'h00, 4'hF, 4'hF);
      model_reset();

      // Round-robin stream on all channels, then the 1010 mask pattern (BURST=1 expectations)
      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b1, 8'(8'h10 + i), 4'hF, 4'hF, 1'b1,
                     (i == 0) ? 4'd0 : 4'(1 << ((i - 1) % 4)), 8'(8'h10 + i - 1)};
      vecs[8]  = '{1'b0, 8'h00, 4'hF,    4'hF, 1'b1, 4'b1000, 8'h17};
      vecs[9]  = '{1'b0, 8'h00, 4'hF,    4'hF, 1'b1, 4'b0000, 8'h00};
      vecs[10] = '{1'b1, 8'hA0, 4'b1010, 4'hF, 1'b1, 4'b0000, 8'h00};
      vecs[11] = '{1'b1, 8'hA1, 4'b1010, 4'hF, 1'b1, 4'b0010, 8'hA0};
      vecs[12] = '{1'b1, 8'hA2, 4'b1010, 4'hF, 1'b1, 4'b1000, 8'hA1};
      vecs[13] = '{1'b0, 8'h00, 4'b1010, 4'hF, 1'b1, 4'b0010, 8'hA2};
      vecs[14] = '{1'b0, 8'h00, 4'b1010, 4'hF, 1'b1, 4'b0000, 8'h00};

      repeat (3) @(negedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("init_out_valid[B%0d]", bursts[m]), 32'(ov_v[m]), 32'd0);
         chk($sformatf("init_busy[B%0d]", bursts[m]), 32'(busy_v[m]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].iv, vecs[i].d, vecs[i].mask, vecs[i].ordy);
         #1;
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready_v[0]), 32'(vecs[i].exp_ir));
         chk($sformatf("vec%0d_out_valid", i), 32'(ov_v[0]), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov != 4'd0)
            chk($sformatf("vec%0d_out_data", i), 32'(data_v[0]), 32'(vecs[i].exp_data));
         rest();
      end

      // Reset while a word is held
      drive(1'b1, 8'h33, 4'hF, 4'h0);
      tick();
      drive(1'b0, 8'h00, 4'hF, 4'h0);
      #1;
      chk("pre_rst_busy", 32'(busy_v[0]), 32'd1);
      #1;
      do_reset();
      #1;
      chk("post_rst_in_ready", 32'(in_ready_v[0]), 32'd1);
      rest();

      // Back-pressure on channel 0 while the producer keeps offering
      drive(1'b1, 8'h55, 4'hF, 4'h0);
      tick();
      drive(1'b1, 8'h66, 4'hF, 4'b1110);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("stall%0d_data", i), 32'(data_v[0]), 32'h55);
         chk($sformatf("stall%0d_sel", i), 32'(sel_v[0]), 32'd0);
         chk($sformatf("stall%0d_in_ready", i), 32'(in_ready_v[0]), 32'd0);
         rest();
      end
      drive(1'b1, 8'h66, 4'hF, 4'hF);
      #1;
      chk("release_in_ready", 32'(in_ready_v[0]), 32'd1);
      rest();
      drive(1'b0, 8'h00, 4'hF, 4'h0);
      #1;
      chk("release_next_ov_b1", 32'(ov_v[0]), 32'b0010);
      chk("release_next_ov_b3", 32'(ov_v[1]), 32'b0001);
      chk("release_next_data", 32'(data_v[0]), 32'h66);
      rest();
      drive(1'b0, 8'h00, 4'hF, 4'hF);
      tick();

      // Burst channel sequence from a fresh reset
      do_reset();
      xlog0.delete();
      xlog1.delete();
      log_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 8'(8'h50 + i), 4'hF, 4'hF);
         tick();
      end
      drive(1'b0, 8'h00, 4'hF, 4'hF);
      tick();
      tick();
      log_en = 1'b0;
      exp_seq1 = '{0, 1, 2, 3, 0, 1, 2};
      exp_seq3 = '{0, 0, 0, 1, 1, 1, 2};
      chk("burst_count_b1", 32'(xlog0.size()), 32'd7);
      chk("burst_count_b3", 32'(xlog1.size()), 32'd7);
      for (int i = 0; i < 7; i++) begin
         if (i < xlog0.size()) chk($sformatf("seq_b1_%0d", i), 32'(xlog0[i]), 32'(exp_seq1[i]));
         if (i < xlog1.size()) chk($sformatf("seq_b3_%0d", i), 32'(xlog1[i]), 32'(exp_seq3[i]));
      end

      // Empty mask blocks input; a held word keeps its channel after being disabled
      do_reset();
      drive(1'b1, 8'h61, 4'h0, 4'hF);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("nomask%0d_in_ready", i), 32'(in_ready_v[0]), 32'd0);
         rest();
      end
      drive(1'b1, 8'h61, 4'b0100, 4'h0);
      tick();
      drive(1'b0, 8'h00, 4'b0000, 4'b1011);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("pinned%0d_ov_b1", i), 32'(ov_v[0]), 32'b0100);
         chk($sformatf("pinned%0d_ov_b3", i), 32'(ov_v[1]), 32'b0100);
         chk($sformatf("pinned%0d_data", i), 32'(data_v[0]), 32'h61);
         rest();
      end
      drive(1'b1, 8'h62, 4'b0000, 4'b0100);
      tick();
      #1;
      chk("pinned_drained", 32'(ov_v[0]), 32'd0);
      rest();

      // Randomized traffic against the reference model
      drive(1'b0, 8'h00, 4'hF, 4'h0);
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = 4'($urandom);
         if ($urandom_range(0, 7) == 0) en_mask = 4'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
